eeprom_access: RTL and testbench
================================

Name: eeprom_access

Overview:
Parametrised I2C EEPROM access controller that performs random reads and page-aware writes through the existing i2c_master byte interface. It sits between a user or host-side engine and i2c_master. It generates the slave address, memory-address bytes, repeated start and data-byte sequencing. Writes are split automatically at EEPROM page boundaries, with a programmable write-cycle wait between pages.

Parameters:
ADDR_BYTES, 2, number of memory-address bytes sent MSB first (legal 1..4)
PAGE_BYTES, 64, EEPROM page size in bytes (power of 2, 1..128)
WR_CYCLE_CLKS, 500000, clk cycles to wait after each page write (tWR); width of the counter is derived from this value

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
slave_addr  in  7  I2C device address, latched on accepted start
mem_addr  in  8*ADDR_BYTES  first memory address, latched on accepted start
nbytes  in  8  byte count, latched on accepted start
op_write  in  1  1 = write, 0 = read; latched on accepted start
start  in  1  request; accepted only in IDLE
busy  out  1  high from the cycle after acceptance until done
done  out  1  one-cycle pulse at operation end
err  out  1  valid with done: 1 = rejected or underrun
wr_data  in  8  write byte from upstream
wr_data_valid  in  1  upstream has a byte on wr_data
wr_data_ready  out  1  one-cycle pulse: wr_data consumed this cycle
rd_data  out  8  read byte
rd_valid  out  1  one-cycle pulse per read byte
i2c_slave_addr  out  7  to i2c_master
i2c_rw  out  1  0 = write, 1 = read
i2c_write_data  out  8  to i2c_master
i2c_nbytes  out  8  bytes in current i2c transaction
i2c_read_data  in  8  from i2c_master
i2c_tx_data_req  in  1  level request for next tx byte
i2c_rx_data_ready  in  1  level flag: rx byte available
i2c_start  out  1  held high for the duration of an i2c transaction

Behaviour:
- Reset (async, reset=0): all outputs 0, state IDLE, counters cleared. Asserting reset mid-operation aborts immediately. i2c_start drops asynchronously. No done is issued.
- IDLE: when start=1, latch all inputs and go to CHECK. start in any other state is ignored.
- CHECK: if nbytes==0, pulse done with err=1 and return to IDLE. No i2c activity occurs.
- Read path:
  - R_START: i2c_rw=0, i2c_nbytes=ADDR_BYTES, i2c_start=1.
  - R_ADDR: send the address bytes MSB first, one per tx_data_req rising edge.
  - R_REP: one cycle. i2c_rw=1, i2c_nbytes=nbytes, i2c_start stays 1 (repeated start).
  - R_DATA: on each rx_data_ready rising edge, rd_data=i2c_read_data and pulse rd_valid for 1 cycle. After byte nbytes, i2c_start=0, pulse done with err=0, go to IDLE.
- Write path:
  - Chunk length = min(remaining, PAGE_BYTES - (addr mod PAGE_BYTES)).
  - W_START: i2c_rw=0, i2c_nbytes=ADDR_BYTES+chunk, i2c_start=1.
  - W_ADDR: send the address bytes as in R_ADDR.
  - W_DATA: on each tx_data_req rising edge, pulse wr_data_ready for 1 cycle and drive i2c_write_data=wr_data in that same cycle.
  - Underrun: if wr_data_valid=0 at that cycle, drive 8'hFF and set a sticky underrun flag. The transfer continues.
  - After the last chunk byte's tx_data_req falls, i2c_start=0, go to W_CYCLE.
  - W_CYCLE: count exactly WR_CYCLE_CLKS cycles. Then, if remaining>0, advance addr by chunk and go to W_START. Otherwise pulse done with err=underrun and go to IDLE.
- Edge detection: tx/rx request edges use a waiting flag. A new byte is serviced only after the flag has seen the level fall. A level held high never double-counts.
- Address arithmetic: addr wraps modulo 2^(8*ADDR_BYTES). Chunking is always based on the wrapped address.
- busy=1 in every state except IDLE. done and busy never overlap: busy drops in the same cycle done rises.
- Simultaneous tx_data_req rise and reset: reset wins.

Test Plan:
- Reset: hold reset=0 with arbitrary inputs -> every output 0. Release reset, pulse start with nbytes=0 -> done=1 and err=1 for exactly 1 cycle, i2c_start never rises.
- Read, ADDR_BYTES=2: slave 0x50, addr 0x1234, nbytes=3, model returns AA, BB, CC -> i2c_write_data 0x12 then 0x34. Repeated start with i2c_rw=1 and i2c_nbytes=3. Three rd_valid pulses carrying AA, BB, CC. done with err=0.
- Page split, PAGE_BYTES=16, WR_CYCLE_CLKS=20: write 4 bytes at 0x001E -> first transaction i2c_nbytes=4 (addr 00 1E, 2 data). Exactly 20 idle cycles with i2c_start=0. Second transaction at 00 20 with 2 data. 4 wr_data_ready pulses total. done with err=0.
- Underrun: write 2 bytes with wr_data_valid=0 on the second request -> second data byte 0xFF, done with err=1.
- ADDR_BYTES=1, address wrap: read 2 bytes at 0xFF -> a single address byte 0xFF is sent, i2c_nbytes=2. Write 2 bytes at 0xFF with PAGE_BYTES=16 -> chunks at 0xFF then 0x00.
- Reset mid-read: assert reset after the first rd_valid -> i2c_start=0 and busy=0 immediately, no done. A following start works normally.

Source files
------------

// File: rtl/eeprom_access.sv
// I2C EEPROM access controller: random reads and page-split writes driven
// through the byte-level i2c_master handshake.
module eeprom_access #(
  parameter int ADDR_BYTES    = 2,
  parameter int PAGE_BYTES    = 64,
  parameter int WR_CYCLE_CLKS = 500000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              slave_addr,
  input  logic [8*ADDR_BYTES-1:0] mem_addr,
  input  logic [7:0]              nbytes,
  input  logic                    op_write,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  input  logic [7:0]              wr_data,
  input  logic                    wr_data_valid,
  output logic                    wr_data_ready,
  output logic [7:0]              rd_data,
  output logic                    rd_valid,
  output logic [6:0]              i2c_slave_addr,
  output logic                    i2c_rw,
  output logic [7:0]              i2c_write_data,
  output logic [7:0]              i2c_nbytes,
  input  logic [7:0]              i2c_read_data,
  input  logic                    i2c_tx_data_req,
  input  logic                    i2c_rx_data_ready,
  output logic                    i2c_start
);

  localparam int AW  = 8 * ADDR_BYTES;
  localparam int WCW = (WR_CYCLE_CLKS > 1) ? $clog2(WR_CYCLE_CLKS) : 1;
  localparam logic [7:0] AB8 = 8'(ADDR_BYTES);
  localparam logic [WCW-1:0] WC_LAST = WCW'(WR_CYCLE_CLKS - 1);

  typedef enum logic [3:0] {
    IDLE, CHECK, R_START, R_ADDR, R_REP, R_DATA,
    W_START, W_ADDR, W_DATA, W_CYCLE
  } state_t;

  state_t         state;
  logic [AW-1:0]  addr_q;
  logic [AW-1:0]  addr_sh;
  logic [7:0]     nbytes_q;
  logic [7:0]     rem_q;
  logic [7:0]     chunk_q;
  logic [7:0]     cnt;
  logic [WCW-1:0] wcnt;
  logic           op_write_q;
  logic           tx_armed;
  logic           rx_armed;
  logic           underrun;
  logic [7:0]     wdata_q;

  logic [7:0] page_off;
  logic [8:0] room;
  logic [7:0] chunk_c;
  logic [7:0] wr_byte;
  logic       tx_fire;
  logic       rx_fire;

  // Bytes left in the current page, capped by what the caller still wants.
  always_comb begin
    page_off = addr_q[7:0] & 8'(PAGE_BYTES - 1);
    room     = 9'(PAGE_BYTES) - {1'b0, page_off};
    chunk_c  = ({1'b0, rem_q} < room) ? rem_q : room[7:0];
  end

  assign wr_byte        = wr_data_valid ? wr_data : 8'hFF;
  assign i2c_write_data = wr_data_ready ? wr_byte : wdata_q;
  assign tx_fire        = i2c_tx_data_req && tx_armed;
  assign rx_fire        = i2c_rx_data_ready && rx_armed;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      addr_q         <= '0;
      addr_sh        <= '0;
      nbytes_q       <= '0;
      rem_q          <= '0;
      chunk_q        <= '0;
      cnt            <= '0;
      wcnt           <= '0;
      op_write_q     <= 1'b0;
      tx_armed       <= 1'b0;
      rx_armed       <= 1'b0;
      underrun       <= 1'b0;
      wdata_q        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      wr_data_ready  <= 1'b0;
      rd_data        <= '0;
      rd_valid       <= 1'b0;
      i2c_slave_addr <= '0;
      i2c_rw         <= 1'b0;
      i2c_nbytes     <= '0;
      i2c_start      <= 1'b0;
    end else begin
      done          <= 1'b0;
      err           <= 1'b0;
      rd_valid      <= 1'b0;
      wr_data_ready <= 1'b0;
      // A request level must be seen low before another byte is serviced.
      if (!i2c_tx_data_req)   tx_armed <= 1'b1;
      if (!i2c_rx_data_ready) rx_armed <= 1'b1;
      if (wr_data_ready) begin
        wdata_q <= wr_byte;
        if (!wr_data_valid) underrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            addr_q         <= mem_addr;
            nbytes_q       <= nbytes;
            rem_q          <= nbytes;
            op_write_q     <= op_write;
            i2c_slave_addr <= slave_addr;
            underrun       <= 1'b0;
            busy           <= 1'b1;
            state          <= CHECK;
          end
        end
        CHECK: begin
          if (nbytes_q == 8'd0) begin
            done  <= 1'b1;
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (op_write_q) begin
            i2c_rw     <= 1'b0;
            i2c_nbytes <= AB8 + chunk_c;
            chunk_q    <= chunk_c;
            addr_sh    <= addr_q;
            cnt        <= '0;
            i2c_start  <= 1'b1;
            state      <= W_START;
          end else begin
            i2c_rw     <= 1'b0;
            i2c_nbytes <= AB8;
            addr_sh    <= addr_q;
            cnt        <= '0;
            i2c_start  <= 1'b1;
            state      <= R_START;
          end
        end
        R_START: state <= R_ADDR;
        R_ADDR: begin
          if (tx_fire && cnt < AB8) begin
            tx_armed <= 1'b0;
            wdata_q  <= addr_sh[AW-1 -: 8];
            addr_sh  <= addr_sh << 8;
            cnt      <= cnt + 8'd1;
          end else if (cnt == AB8 && !i2c_tx_data_req) begin
            i2c_rw     <= 1'b1;
            i2c_nbytes <= nbytes_q;
            state      <= R_REP;
          end
        end
        R_REP: begin
          cnt   <= '0;
          state <= R_DATA;
        end
        R_DATA: begin
          if (rx_fire) begin
            rx_armed <= 1'b0;
            rd_data  <= i2c_read_data;
            rd_valid <= 1'b1;
            cnt      <= cnt + 8'd1;
            if (cnt + 8'd1 == nbytes_q) begin
              i2c_start <= 1'b0;
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        W_START: state <= W_ADDR;
        W_ADDR: begin
          if (tx_fire) begin
            tx_armed <= 1'b0;
            wdata_q  <= addr_sh[AW-1 -: 8];
            addr_sh  <= addr_sh << 8;
            if (cnt == AB8 - 8'd1) begin
              cnt   <= '0;
              state <= W_DATA;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        W_DATA: begin
          if (tx_fire && cnt < chunk_q) begin
            tx_armed      <= 1'b0;
            wr_data_ready <= 1'b1;
            cnt           <= cnt + 8'd1;
          end else if (cnt == chunk_q && !i2c_tx_data_req && !wr_data_ready) begin
            // Advance to the next chunk now so W_CYCLE can size it in advance.
            i2c_start <= 1'b0;
            addr_q    <= addr_q + AW'(chunk_q);
            rem_q     <= rem_q - chunk_q;
            wcnt      <= '0;
            state     <= W_CYCLE;
          end
        end
        W_CYCLE: begin
          if (wcnt == WC_LAST) begin
            if (rem_q != 8'd0) begin
              i2c_rw     <= 1'b0;
              i2c_nbytes <= AB8 + chunk_c;
              chunk_q    <= chunk_c;
              addr_sh    <= addr_q;
              cnt        <= '0;
              i2c_start  <= 1'b1;
              state      <= W_START;
            end else begin
              done  <= 1'b1;
              err   <= underrun;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            wcnt <= wcnt + WCW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eeprom_access.sv
// Bench for eeprom_access: emulates i2c_master and the upstream byte source,
// and checks observed bus traffic against a page-chunking reference model.
module tb_eeprom_access;

  localparam int PAGE = 16;
  localparam int WRC  = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start0, start1;
  logic [6:0]  slave_addr;
  logic [15:0] mem_addr;
  logic [7:0]  nbytes;
  logic        op_write;
  logic [7:0]  wr_data;
  logic        wr_data_valid;
  logic [7:0]  i2c_read_data;
  logic        tx_req, rx_rdy;

  logic       busy0, done0, err0, wrdy0, rdv0, rw0, ist0;
  logic [7:0] rdd0, iwd0, inb0;
  logic [6:0] isa0;
  logic       busy1, done1, err1, wrdy1, rdv1, rw1, ist1;
  logic [7:0] rdd1, iwd1, inb1;
  logic [6:0] isa1;

  eeprom_access #(.ADDR_BYTES(2), .PAGE_BYTES(PAGE), .WR_CYCLE_CLKS(WRC)) dut0 (
    .clk(clk), .reset(rst_n), .slave_addr(slave_addr), .mem_addr(mem_addr),
    .nbytes(nbytes), .op_write(op_write), .start(start0), .busy(busy0),
    .done(done0), .err(err0), .wr_data(wr_data), .wr_data_valid(wr_data_valid),
    .wr_data_ready(wrdy0), .rd_data(rdd0), .rd_valid(rdv0),
    .i2c_slave_addr(isa0), .i2c_rw(rw0), .i2c_write_data(iwd0),
    .i2c_nbytes(inb0), .i2c_read_data(i2c_read_data),
    .i2c_tx_data_req(tx_req), .i2c_rx_data_ready(rx_rdy), .i2c_start(ist0));

  eeprom_access #(.ADDR_BYTES(1), .PAGE_BYTES(PAGE), .WR_CYCLE_CLKS(WRC)) dut1 (
    .clk(clk), .reset(rst_n), .slave_addr(slave_addr), .mem_addr(mem_addr[7:0]),
    .nbytes(nbytes), .op_write(op_write), .start(start1), .busy(busy1),
    .done(done1), .err(err1), .wr_data(wr_data), .wr_data_valid(wr_data_valid),
    .wr_data_ready(wrdy1), .rd_data(rdd1), .rd_valid(rdv1),
    .i2c_slave_addr(isa1), .i2c_rw(rw1), .i2c_write_data(iwd1),
    .i2c_nbytes(inb1), .i2c_read_data(i2c_read_data),
    .i2c_tx_data_req(tx_req), .i2c_rx_data_ready(rx_rdy), .i2c_start(ist1));

  logic       sel;
  logic       c_busy, c_done, c_err, c_wrdy, c_rdv, c_rw, c_ist;
  logic [7:0] c_rdd, c_iwd, c_inb;
  logic [6:0] c_isa;

  always_comb begin
    c_busy = sel ? busy1 : busy0;  c_done = sel ? done1 : done0;
    c_err  = sel ? err1  : err0;   c_wrdy = sel ? wrdy1 : wrdy0;
    c_rdv  = sel ? rdv1  : rdv0;   c_rw   = sel ? rw1   : rw0;
    c_ist  = sel ? ist1  : ist0;   c_rdd  = sel ? rdd1  : rdd0;
    c_iwd  = sel ? iwd1  : iwd0;   c_inb  = sel ? inb1  : inb0;
    c_isa  = sel ? isa1  : isa0;
  end

  int checks = 0;
  int errors = 0;

  logic [7:0] wd_q[$];
  logic       wv_q[$];
  logic [7:0] rx_q[$];
  int         obs_hdr[$], exp_hdr[$];
  logic [7:0] obs_tx[$],  exp_tx[$];
  logic [7:0] obs_rd[$],  exp_rd[$];
  int         obs_gap[$], exp_gap[$];
  int         n_ready;
  bit         got_done, got_err, exp_err;

  typedef struct {
    bit inst; bit wr; int addr; int n; int uslot; bit exp_err; int exp_txn;
  } vec_t;
  vec_t vecs[8];

  task automatic check_output(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
    end
  endtask

  task automatic start_op(input bit inst, input int sa, input int addr, input int n, input bit wr);
    @(negedge clk);
    sel = inst;
    slave_addr = 7'(sa);
    mem_addr = 16'(addr);
    nbytes = 8'(n);
    op_write = wr;
    wr_data = (wd_q.size() > 0) ? wd_q[0] : 8'h00;
    wr_data_valid = (wv_q.size() > 0) ? wv_q[0] : 1'b0;
    if (inst) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    check_output("busy_after_start", c_busy, 1);
  endtask

  // Behaves like i2c_master plus the upstream FIFO, sampling on falling edges.
  task automatic run_op(input int budget, input bit abort_on_rd);
    int ph = 0, step = 0, bidx = 0, nb = 0, slot = 0, ridx = 0, gap = 0, cyc = 0;
    bit adv = 0, seen = 0;
    obs_hdr.delete(); obs_tx.delete(); obs_rd.delete(); obs_gap.delete();
    n_ready = 0; got_done = 0; got_err = 0;
    while (!got_done && cyc < budget && !(abort_on_rd && obs_rd.size() > 0)) begin
      @(negedge clk);
      cyc++;
      if (adv) begin
        slot++;
        wr_data = (slot < wd_q.size()) ? wd_q[slot] : 8'h00;
        wr_data_valid = (slot < wv_q.size()) ? wv_q[slot] : 1'b0;
        adv = 0;
      end
      if (c_wrdy) begin n_ready++; adv = 1; end
      if (c_rdv) obs_rd.push_back(c_rdd);
      if (c_ist) begin
        if (seen && gap > 0) obs_gap.push_back(gap);
        gap = 0; seen = 1;
      end else if (seen && c_busy) gap++;
      if (c_done) begin
        got_done = 1; got_err = c_err;
        if (gap > 0) obs_gap.push_back(gap);
        check_output("busy_low_at_done", c_busy, 0);
      end
      case (ph)
        0: if (c_ist) begin
             obs_hdr.push_back(int'(c_rw) * 256 + int'(c_inb));
             nb = c_inb; bidx = 0; step = 0; ph = c_rw ? 3 : 1;
           end
        1: begin
             if (step == 0) tx_req = 1'b1;
             if (step == 4) begin obs_tx.push_back(c_iwd); tx_req = 1'b0; end
             if (step == 6) begin
               bidx++; step = -1;
               if (bidx == nb) ph = 2;
             end
             step++;
           end
        2: if (!c_ist) ph = 0;
           else if (c_rw) begin
             obs_hdr.push_back(256 + int'(c_inb));
             nb = c_inb; bidx = 0; step = 0; ph = 3;
           end
        default: begin
             if (step == 0) begin
               i2c_read_data = (ridx < rx_q.size()) ? rx_q[ridx] : 8'h00;
               rx_rdy = 1'b1;
             end
             if (step == 2) rx_rdy = 1'b0;
             if (step == 4) begin
               bidx++; ridx++; step = -1;
               if (bidx == nb) ph = 2;
             end
             step++;
           end
      endcase
    end
    if (!got_done && !abort_on_rd) begin
      check_output("done_timeout", 0, 1);
      rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    end
    tx_req = 1'b0;
    rx_rdy = 1'b0;
  endtask

  // Expected traffic from the page-chunking rules, then comparison.
  task automatic apply_stimulus(input bit inst, input bit wr, input int addr, input int n,
                                input int uslot, input bit rand_valid);
    int ab = inst ? 1 : 2;
    int amask = inst ? 'hFF : 'hFFFF;
    int a = addr & amask;
    int rem = n, k = 0, c, sa;
    wd_q.delete(); wv_q.delete(); rx_q.delete();
    exp_hdr.delete(); exp_tx.delete(); exp_rd.delete(); exp_gap.delete();
    exp_err = 0;
    for (int i = 0; i < n; i++) begin
      wd_q.push_back(8'($urandom));
      wv_q.push_back(rand_valid ? ($urandom_range(0, 5) != 0) : (i != uslot));
      rx_q.push_back(8'('hAA + 'h11 * i));
    end
    if (!wr) begin
      exp_hdr.push_back(ab);
      for (int b = ab - 1; b >= 0; b--) exp_tx.push_back(8'(a >> (8 * b)));
      exp_hdr.push_back(256 + n);
      for (int i = 0; i < n; i++) exp_rd.push_back(rx_q[i]);
    end else begin
      while (rem > 0) begin
        c = PAGE - (a % PAGE);
        if (rem < c) c = rem;
        exp_hdr.push_back(ab + c);
        for (int b = ab - 1; b >= 0; b--) exp_tx.push_back(8'(a >> (8 * b)));
        for (int j = 0; j < c; j++) begin
          exp_tx.push_back(wv_q[k] ? wd_q[k] : 8'hFF);
          if (!wv_q[k]) exp_err = 1;
          k++;
        end
        exp_gap.push_back(WRC);
        a = (a + c) & amask;
        rem -= c;
      end
    end
    sa = $urandom_range(0, 127);
    start_op(inst, sa, addr, n, wr);
    run_op(6000, 0);
    @(negedge clk);
    check_output("done_pulse_width", c_done, 0);
    check_output("err", got_err, exp_err);
    check_output("slave_addr", c_isa, sa);
    check_output("wr_ready_count", n_ready, wr ? n : 0);
    check_output("hdr_count", obs_hdr.size(), exp_hdr.size());
    for (int i = 0; i < exp_hdr.size() && i < obs_hdr.size(); i++)
      check_output($sformatf("hdr[%0d]", i), obs_hdr[i], exp_hdr[i]);
    check_output("tx_count", obs_tx.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < obs_tx.size(); i++)
      check_output($sformatf("tx[%0d]", i), obs_tx[i], exp_tx[i]);
    check_output("rd_count", obs_rd.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size() && i < obs_rd.size(); i++)
      check_output($sformatf("rd[%0d]", i), obs_rd[i], exp_rd[i]);
    check_output("gap_count", obs_gap.size(), exp_gap.size());
    for (int i = 0; i < exp_gap.size() && i < obs_gap.size(); i++)
      check_output($sformatf("gap[%0d]", i), obs_gap[i], exp_gap[i]);
  endtask

  initial begin
    int dcnt;
    bit st_hi;
    vecs[0] = '{0, 0, 'h1234, 3, -1, 0, 2};
    vecs[1] = '{0, 1, 'h001E, 4, -1, 0, 2};
    vecs[2] = '{0, 1, 'h0040, 2, 1, 1, 1};
    vecs[3] = '{1, 0, 'h00FF, 2, -1, 0, 2};
    vecs[4] = '{1, 1, 'h00FF, 2, -1, 0, 2};
    vecs[5] = '{0, 1, 'hFFFE, 20, -1, 0, 3};
    vecs[6] = '{0, 1, 'h0010, 16, -1, 0, 1};
    vecs[7] = '{0, 0, 'h0000, 1, -1, 0, 2};

    // Reset held with arbitrary inputs toggling.
    rst_n = 1'b0; sel = 1'b0;
    start0 = 1'b1; start1 = 1'b1; slave_addr = 7'h5A; mem_addr = 16'hBEEF;
    nbytes = 8'h07; op_write = 1'b1; wr_data = 8'hC3; wr_data_valid = 1'b1;
    i2c_read_data = 8'h99; tx_req = 1'b1; rx_rdy = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      sel = i[0];
      #1;
      check_output("rst_busy", c_busy, 0);   check_output("rst_done", c_done, 0);
      check_output("rst_err", c_err, 0);     check_output("rst_wrdy", c_wrdy, 0);
      check_output("rst_rdv", c_rdv, 0);     check_output("rst_rdd", c_rdd, 0);
      check_output("rst_isa", c_isa, 0);     check_output("rst_rw", c_rw, 0);
      check_output("rst_iwd", c_iwd, 0);     check_output("rst_inb", c_inb, 0);
      check_output("rst_ist", c_ist, 0);
    end
    start0 = 1'b0; start1 = 1'b0; tx_req = 1'b0; rx_rdy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Zero-length request is rejected without touching the bus.
    wd_q.delete(); wv_q.delete();
    start_op(0, 'h50, 'h0100, 0, 0);
    dcnt = 0; st_hi = 0;
    repeat (8) begin
      @(negedge clk);
      if (c_done) begin dcnt++; check_output("zero_len_err", c_err, 1); end
      if (c_ist) st_hi = 1;
    end
    check_output("zero_len_done_cycles", dcnt, 1);
    check_output("zero_len_i2c_start", st_hi, 0);

    // Reset lands right after the first read byte.
    rx_q.delete();
    for (int i = 0; i < 4; i++) rx_q.push_back(8'(i + 1));
    start_op(0, 'h50, 'h0200, 4, 0);
    run_op(2000, 1);
    check_output("abort_saw_rd", obs_rd.size(), 1);
    rst_n = 1'b0;
    #1;
    check_output("abort_i2c_start", c_ist, 0);
    check_output("abort_busy", c_busy, 0);
    dcnt = 0;
    repeat (4) begin @(negedge clk); dcnt += int'(c_done); end
    rst_n = 1'b1;
    repeat (4) begin @(negedge clk); dcnt += int'(c_done); end
    check_output("abort_no_done", dcnt, 0);

    for (int v = 0; v < 8; v++) begin
      apply_stimulus(vecs[v].inst, vecs[v].wr, vecs[v].addr, vecs[v].n, vecs[v].uslot, 0);
      check_output($sformatf("vec%0d_err", v), got_err, vecs[v].exp_err);
      check_output($sformatf("vec%0d_txn", v), obs_hdr.size(), vecs[v].exp_txn);
    end

    for (int r = 0; r < 8; r++)
      apply_stimulus($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 65535),
                     $urandom_range(1, 40), -1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
